// File: rtl/avr_prefetch.sv
// Instruction prefetch: streams sequential program words into a small FIFO and presents head/next word with PC.
// Latency: a redirect (or reset release) shows a valid head 2 cycles later; one word per cycle sustained.
// Backpressure: reads issue only while occupancy plus the in-flight read is below DEPTH, so the FIFO never overflows.
module avr_prefetch #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          CLK,
    input  logic          RST,
    output logic [15:0]   prog_addr,
    output logic          prog_rd,
    input  logic [15:0]   prog_data,
    input  logic          redirect,
    input  logic [15:0]   redirect_pc,
    input  logic [1:0]    advance,
    output logic [15:0]   instr,
    output logic [15:0]   instr_pc,
    output logic          instr_valid,
    output logic [15:0]   instr_ext,
    output logic          ext_valid,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] dat;
    } entry_t;

    entry_t          fifo_q [DEPTH];
    entry_t          fifo_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     fetch_pc_q, fetch_pc_d;
    logic [15:0]     inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;
    logic            push;
    logic [1:0]      pop_n;
    logic [CW:0]     occ;
    logic [PW-1:0]   rd_ptr_nx;

    // Issue decision: a redirect always fetches its target; otherwise fetch while there is room
    always_comb begin
        prog_rd   = 1'b0;
        prog_addr = 16'h0000;
        occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        if (!RST) begin
            if (redirect) begin
                prog_rd   = 1'b1;
                prog_addr = redirect_pc;
            end else begin
                prog_addr = fetch_pc_q;
                prog_rd   = (occ < DEPTH_C);
            end
        end
    end

    // Next state: push returning data, pop on advance, flush and restart on redirect
    always_comb begin
        fifo_d        = fifo_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = prog_rd;
        push          = 1'b0;
        pop_n         = 2'd0;
        if (redirect) begin
            // Data returning this cycle belongs to the old stream and is dropped
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            fetch_pc_d    = redirect_pc + 16'd1;
            inflight_pc_d = redirect_pc;
        end else begin
            push = inflight_q;
            if (advance == 2'b01 && count_q != '0) begin
                pop_n = 2'd1;
            end else if (advance == 2'b10 && count_q >= CW'(2)) begin
                pop_n = 2'd2;
            end
            if (push) begin
                fifo_d[wr_ptr_q] = '{pc: inflight_pc_q, dat: prog_data};
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            rd_ptr_d = rd_ptr_q + PW'(pop_n);
            count_d  = count_q + CW'(push) - CW'(pop_n);
            if (prog_rd) begin
                fetch_pc_d    = fetch_pc_q + 16'd1;
                inflight_pc_d = fetch_pc_q;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fetch_pc_q    <= 16'h0000;
            inflight_pc_q <= 16'h0000;
            inflight_q    <= 1'b0;
        end else begin
            fifo_q        <= fifo_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    // Outputs decoded from FIFO state only; invalid slots read as NOP at PC 0
    always_comb begin
        rd_ptr_nx   = rd_ptr_q + PW'(1);
        instr_valid = (count_q != '0);
        ext_valid   = (count_q >= CW'(2));
        instr       = instr_valid ? fifo_q[rd_ptr_q].dat  : 16'h0000;
        instr_pc    = instr_valid ? fifo_q[rd_ptr_q].pc   : 16'h0000;
        instr_ext   = ext_valid   ? fifo_q[rd_ptr_nx].dat : 16'h0000;
        count       = count_q;
    end

endmodule

// File: tb/tb_avr_prefetch.sv
module tb_avr_prefetch;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] prog_addr;
    logic        prog_rd;
    logic [15:0] prog_data = 16'h0000;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [1:0]  advance = 2'b00;
    logic [15:0] instr, instr_pc, instr_ext;
    logic        instr_valid, ext_valid;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];
    logic [15:0] addr_q[$];

    avr_prefetch #(.DEPTH(4), .CW(3)) dut (
        .CLK(CLK), .RST(RST),
        .prog_addr(prog_addr), .prog_rd(prog_rd), .prog_data(prog_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .advance(advance),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ext(instr_ext), .ext_valid(ext_valid), .count(count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // Synchronous program memory: data valid the cycle after the read strobe
    always @(posedge CLK) begin
        if (prog_rd) prog_data <= memf(prog_addr);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; redirect = 1'b0; advance = 2'b00; redirect_pc = 16'h0000;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (prog_rd !== 1'b0)      begin n_err++; $display("FAIL rst_prog_rd got %b exp 0", prog_rd); end
        n_cmp++; if (prog_addr !== 16'h0)   begin n_err++; $display("FAIL rst_prog_addr got %h exp 0000", prog_addr); end
        n_cmp++; if (count !== 3'd0)        begin n_err++; $display("FAIL rst_count got %0d exp 0", count); end
        n_cmp++; if (instr_valid !== 1'b0)  begin n_err++; $display("FAIL rst_instr_valid got %b exp 0", instr_valid); end
        n_cmp++; if (ext_valid !== 1'b0)    begin n_err++; $display("FAIL rst_ext_valid got %b exp 0", ext_valid); end
        n_cmp++; if (instr !== 16'h0)       begin n_err++; $display("FAIL rst_instr got %h exp 0000", instr); end
        n_cmp++; if (instr_pc !== 16'h0)    begin n_err++; $display("FAIL rst_instr_pc got %h exp 0000", instr_pc); end
        n_cmp++; if (instr_ext !== 16'h0)   begin n_err++; $display("FAIL rst_instr_ext got %h exp 0000", instr_ext); end
    endtask

    task automatic test_fill();
        logic [15:0] e;
        do_reset();
        addr_q = {};
        for (int i = 0; i < 4; i++) addr_q.push_back(16'(i));
        for (int c = 0; c < 7; c++) begin
            advance = 2'b00;
            #1;
            if (prog_rd) begin
                n_cmp++;
                if (addr_q.size() == 0) begin
                    n_err++; $display("FAIL fill_extra_read cycle %0d addr %h exp no read", c, prog_addr);
                end else begin
                    e = addr_q.pop_front();
                    if (prog_addr !== e) begin n_err++; $display("FAIL fill_addr cycle %0d got %h exp %h", c, prog_addr, e); end
                end
            end
            tick();
        end
        n_cmp++; if (addr_q.size() != 0)    begin n_err++; $display("FAIL fill_reads_missing got %0d left exp 0", addr_q.size()); end
        n_cmp++; if (count !== 3'd4)        begin n_err++; $display("FAIL fill_count got %0d exp 4", count); end
        n_cmp++; if (instr !== 16'hA000)    begin n_err++; $display("FAIL fill_instr got %h exp A000", instr); end
        n_cmp++; if (instr_pc !== 16'h0)    begin n_err++; $display("FAIL fill_pc got %h exp 0000", instr_pc); end
        n_cmp++; if (instr_ext !== 16'hA001) begin n_err++; $display("FAIL fill_ext got %h exp A001", instr_ext); end
        n_cmp++; if (ext_valid !== 1'b1)    begin n_err++; $display("FAIL fill_ext_valid got %b exp 1", ext_valid); end
    endtask

    task automatic test_pop2();
        // FIFO full with pcs 0..3 on entry
        advance = 2'b10; #1; tick();
        advance = 2'b00; #1;
        n_cmp++; if (instr_pc !== 16'h2)     begin n_err++; $display("FAIL pop2_pc got %h exp 0002", instr_pc); end
        n_cmp++; if (instr !== 16'hA002)     begin n_err++; $display("FAIL pop2_instr got %h exp A002", instr); end
        n_cmp++; if (instr_ext !== 16'hA003) begin n_err++; $display("FAIL pop2_ext got %h exp A003", instr_ext); end
        n_cmp++; if (count !== 3'd2)         begin n_err++; $display("FAIL pop2_count got %0d exp 2", count); end
        // Reach count=1 via a redirect, then request a two-word pop
        redirect = 1'b1; redirect_pc = 16'h0200; #1; tick();
        redirect = 1'b0; #1; tick();
        n_cmp++; if (count !== 3'd1)         begin n_err++; $display("FAIL pop2_pre_count got %0d exp 1", count); end
        advance = 2'b10; #1; tick();
        advance = 2'b00; #1;
        n_cmp++; if (instr_pc !== 16'h0200)  begin n_err++; $display("FAIL pop2_partial_pc got %h exp 0200", instr_pc); end
        n_cmp++; if (count !== 3'd2)         begin n_err++; $display("FAIL pop2_partial_count got %0d exp 2", count); end
    endtask

    task automatic test_stream();
        logic [15:0] e;
        logic        ev;
        do_reset();
        exp_q = {};
        for (int i = 0; i < 10; i++) exp_q.push_back(16'(i));
        for (int c = 0; c < 12; c++) begin
            advance = 2'b01;
            #1;
            ev = (c >= 2);
            n_cmp++; if (instr_valid !== ev) begin n_err++; $display("FAIL stream_valid cycle %0d got %b exp %b", c, instr_valid, ev); end
            n_cmp++; if (prog_rd !== 1'b1)   begin n_err++; $display("FAIL stream_prog_rd cycle %0d got %b exp 1", c, prog_rd); end
            n_cmp++; if (count > 3'd2)       begin n_err++; $display("FAIL stream_count cycle %0d got %0d exp <=2", c, count); end
            if (instr_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (instr_pc !== e || instr !== memf(e)) begin
                    n_err++; $display("FAIL stream_word cycle %0d got pc %h instr %h exp pc %h instr %h", c, instr_pc, instr, e, memf(e));
                end
            end
            tick();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stream_missing got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        logic [15:0] e;
        do_reset();
        repeat (6) tick();
        advance = 2'b01; #1; tick();
        advance = 2'b00; #1;
        n_cmp++; if (prog_rd !== 1'b1 || prog_addr !== 16'h4) begin n_err++; $display("FAIL redir_refill got rd %b addr %h exp rd 1 addr 0004", prog_rd, prog_addr); end
        tick();
        redirect = 1'b1; redirect_pc = 16'h0100; advance = 2'b01; #1;
        n_cmp++; if (prog_addr !== 16'h0100) begin n_err++; $display("FAIL redir_addr got %h exp 0100", prog_addr); end
        n_cmp++; if (prog_rd !== 1'b1)       begin n_err++; $display("FAIL redir_rd got %b exp 1", prog_rd); end
        tick();
        redirect = 1'b0; advance = 2'b00; #1;
        n_cmp++; if (instr_valid !== 1'b0)   begin n_err++; $display("FAIL redir_flush_valid got %b exp 0", instr_valid); end
        n_cmp++; if (count !== 3'd0)         begin n_err++; $display("FAIL redir_flush_count got %0d exp 0", count); end
        tick();
        exp_q = {16'h0100, 16'h0101, 16'h0102, 16'h0103};
        for (int c = 0; c < 8; c++) begin
            advance = 2'b01;
            #1;
            if (c == 0) begin
                n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL redir_latency got valid %b exp 1", instr_valid); end
            end
            if (instr_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (instr_pc !== e || instr !== memf(e)) begin
                    n_err++; $display("FAIL redir_word got pc %h instr %h exp pc %h instr %h", instr_pc, instr, e, memf(e));
                end
            end
            tick();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL redir_missing got %0d left exp 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        logic [15:0] e;
        redirect = 1'b1; redirect_pc = 16'hFFFE; advance = 2'b01; #1;
        n_cmp++; if (prog_addr !== 16'hFFFE) begin n_err++; $display("FAIL wrap_redir_addr got %h exp FFFE", prog_addr); end
        addr_q = {16'hFFFF, 16'h0000, 16'h0001, 16'h0002};
        exp_q  = {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        tick();
        redirect = 1'b0;
        for (int c = 0; c < 8; c++) begin
            advance = 2'b01;
            #1;
            if (prog_rd && addr_q.size() > 0) begin
                e = addr_q.pop_front();
                n_cmp++; if (prog_addr !== e) begin n_err++; $display("FAIL wrap_addr got %h exp %h", prog_addr, e); end
            end
            if (instr_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (instr_pc !== e || instr !== memf(e)) begin
                    n_err++; $display("FAIL wrap_word got pc %h instr %h exp pc %h instr %h", instr_pc, instr, e, memf(e));
                end
            end
            tick();
        end
        n_cmp++; if (addr_q.size() != 0 || exp_q.size() != 0) begin
            n_err++; $display("FAIL wrap_missing got %0d addrs %0d words left exp 0", addr_q.size(), exp_q.size());
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] e;
        advance = 2'b01;
        #2;
        RST = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd0)       begin n_err++; $display("FAIL arst_count got %0d exp 0", count); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b exp 0", instr_valid); end
        n_cmp++; if (prog_rd !== 1'b0)     begin n_err++; $display("FAIL arst_prog_rd got %b exp 0", prog_rd); end
        n_cmp++; if (instr !== 16'h0)      begin n_err++; $display("FAIL arst_instr got %h exp 0000", instr); end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        addr_q = {16'h0000, 16'h0001, 16'h0002, 16'h0003};
        exp_q  = {16'h0000, 16'h0001, 16'h0002, 16'h0003};
        for (int c = 0; c < 8; c++) begin
            advance = 2'b01;
            #1;
            if (prog_rd && addr_q.size() > 0) begin
                e = addr_q.pop_front();
                n_cmp++; if (prog_addr !== e) begin n_err++; $display("FAIL arst_restart_addr got %h exp %h", prog_addr, e); end
            end
            if (instr_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (instr_pc !== e || instr !== memf(e)) begin
                    n_err++; $display("FAIL arst_word got pc %h instr %h exp pc %h instr %h", instr_pc, instr, e, memf(e));
                end
            end
            tick();
        end
        n_cmp++; if (addr_q.size() != 0 || exp_q.size() != 0) begin
            n_err++; $display("FAIL arst_missing got %0d addrs %0d words left exp 0", addr_q.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_pop2();
        test_stream();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
